// File: rtl/alu_vec_arbiter.sv
// Two-client round-robin arbiter and sequencer for the shared vector ALU.
// Operands are registered onto the ALU, the result is captured one cycle later and returned to the owner.
module alu_vec_arbiter #(
    parameter int LANES = 3,
    parameter int WIDTH = 18,
    parameter int OPW   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic                   req1_valid,
    output logic                   req0_ready,
    output logic                   req1_ready,
    input  logic [LANES*WIDTH-1:0] req0_a,
    input  logic [LANES*WIDTH-1:0] req0_b,
    input  logic [LANES*WIDTH-1:0] req1_a,
    input  logic [LANES*WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]         req0_op,
    input  logic [OPW-1:0]         req1_op,
    output logic [LANES*WIDTH-1:0] alu_a,
    output logic [LANES*WIDTH-1:0] alu_b,
    output logic [OPW-1:0]         alu_op,
    input  logic [LANES*WIDTH-1:0] alu_result,
    input  logic [3:0]             alu_flags,
    output logic                   rsp0_valid,
    output logic                   rsp1_valid,
    input  logic                   rsp0_ready,
    input  logic                   rsp1_ready,
    output logic [LANES*WIDTH-1:0] rsp_result,
    output logic [3:0]             rsp_flags,
    output logic                   busy,
    output logic [15:0]            op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       owner;
    logic       grant_id;
    logic       in_idle;
    logic       accept;
    logic       owner_ready;

    // On a tie the client that did not win last time gets the grant.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Readies are also gated by reset so nothing looks accepted while reset is held.
    assign in_idle     = (state == IDLE) && reset;
    assign req0_ready  = in_idle && req0_valid && !grant_id;
    assign req1_ready  = in_idle && req1_valid && grant_id;
    assign accept      = in_idle && (req0_valid || req1_valid);
    assign owner_ready = owner ? rsp1_ready : rsp0_ready;

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= grant_id ? req1_a  : req0_a;
                        alu_b      <= grant_id ? req1_b  : req0_b;
                        alu_op     <= grant_id ? req1_op : req0_op;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    state      <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        op_count <= op_count + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
